// File: rtl/vfd_clk_pkg.sv
// rtl/vfd_clk_pkg.sv - shared encodings and defaults for the VFD ramped clock divider
package vfd_clk_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_STEP_W      = 8;
    // Half-period minus 1 of the original fixed drive-frequency divider.
    localparam int LEGACY_DIV_10HZ = 1175;

    typedef enum logic {
        LOCKED = 1'b0,
        RAMP   = 1'b1
    } state_t;

endpackage

// File: rtl/sat_step.sv
// rtl/sat_step.sv - saturating move of a setpoint toward a target by at most one step
// Ports:
//   cur  - present setpoint
//   tgt  - target setpoint
//   step - largest allowed change (zero-extended); 0 means jump straight to tgt
//   nxt  - new setpoint, never past tgt and never wrapped
module sat_step #(
    parameter int CNT_W  = 16,
    parameter int STEP_W = 8
) (
    input  logic [CNT_W-1:0]  cur,
    input  logic [CNT_W-1:0]  tgt,
    input  logic [STEP_W-1:0] step,
    output logic [CNT_W-1:0]  nxt
);

    logic [CNT_W:0] step_ext;
    logic [CNT_W:0] up;
    logic [CNT_W:0] gap;

    assign step_ext = {{(CNT_W + 1 - STEP_W){1'b0}}, step};

    always_comb begin
        // One spare bit keeps cur+step from wrapping near full scale.
        up  = {1'b0, cur} + step_ext;
        gap = {1'b0, cur} - {1'b0, tgt};
        nxt = cur;
        if (step == '0) begin
            nxt = tgt;
        end else if (cur < tgt) begin
            nxt = (up >= {1'b0, tgt}) ? tgt : up[CNT_W-1:0];
        end else if (cur > tgt) begin
            // gap > step implies step < cur, so the narrow subtraction is safe.
            nxt = (gap <= step_ext) ? tgt : cur - step_ext[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/vfd_ramp_clk_div.sv
// rtl/vfd_ramp_clk_div.sv - programmable 50% clock divider with soft half-period ramp
// Ports:
//   clk_in, reset          - system clock, synchronous active-high reset
//   enable                 - run enable; low idles the output at 0
//   target_div/target_valid - requested half-period minus 1 and its load strobe
//   ramp_step              - max change of cur_div per output half-period (0 = jump)
//   clk_out, tick          - divided square wave and one-cycle pulse on each toggle
//   cur_div                - half-period minus 1 currently in use
//   at_target, busy        - cur_div equals latched target / ramp in progress
module vfd_ramp_clk_div
    import vfd_clk_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int STEP_W   = DEF_STEP_W,
    parameter int INIT_DIV = LEGACY_DIV_10HZ,
    parameter int DIV_MIN  = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  target_div,
    input  logic              target_valid,
    input  logic [STEP_W-1:0] ramp_step,
    output logic              clk_out,
    output logic              tick,
    output logic [CNT_W-1:0]  cur_div,
    output logic              at_target,
    output logic              busy
);

    localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_DIV);
    localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(DIV_MIN);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] step_div;
    logic [CNT_W-1:0] cur_div_next;
    logic [CNT_W-1:0] target_next;
    logic             boundary;
    state_t           state;
    state_t           state_next;

    assign boundary = enable && (counter == cur_div);

    // Step is computed from the target held before any same-cycle load.
    sat_step #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W)
    ) u_sat_step (
        .cur  (cur_div),
        .tgt  (target_reg),
        .step (ramp_step),
        .nxt  (step_div)
    );

    assign cur_div_next = boundary ? step_div : cur_div;
    assign target_next  = target_valid ? ((target_div < MIN_V) ? MIN_V : target_div)
                                       : target_reg;
    assign busy         = (state == RAMP);

    always_comb begin
        state_next = state;
        case (state)
            // A zero step jumps at the next boundary, so it never counts as ramping.
            LOCKED: if (ramp_step != '0 && cur_div_next != target_reg) state_next = RAMP;
            RAMP:   if (boundary && step_div == target_reg) state_next = LOCKED;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            counter    <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            cur_div    <= INIT_V;
            target_reg <= INIT_V;
            state      <= LOCKED;
            at_target  <= 1'b1;
        end else begin
            target_reg <= target_next;
            cur_div    <= cur_div_next;
            state      <= state_next;
            at_target  <= (cur_div_next == target_next);
            if (!enable) begin
                counter <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (boundary) begin
                counter <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
            end else begin
                counter <= counter + CNT_W'(1);
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vfd_ramp_clk_div.sv
// tb/tb_vfd_ramp_clk_div.sv - self-checking bench for vfd_ramp_clk_div
module tb_vfd_ramp_clk_div;

    localparam int CNT_W   = 16;
    localparam int STEP_W  = 8;
    localparam int INIT    = 1175;
    localparam int DIV_MIN = 1;

    logic              clk_in = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic [CNT_W-1:0]  target_div = '0;
    logic              target_valid = 1'b0;
    logic [STEP_W-1:0] ramp_step = '0;
    logic              clk_out;
    logic              tick;
    logic [CNT_W-1:0]  cur_div;
    logic              at_target;
    logic              busy;

    int errors = 0;
    int checks = 0;
    bit busy_seen;

    vfd_ramp_clk_div #(
        .CNT_W    (CNT_W),
        .STEP_W   (STEP_W),
        .INIT_DIV (INIT),
        .DIV_MIN  (DIV_MIN)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable       (enable),
        .target_div   (target_div),
        .target_valid (target_valid),
        .ramp_step    (ramp_step),
        .clk_out      (clk_out),
        .tick         (tick),
        .cur_div      (cur_div),
        .at_target    (at_target),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int tgt;
        int step;
        int e1;
        int e2;
        int e3;
        bit busy_exp;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        target_valid = 1'b0;
        cyc1();
        reset = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc1();
            n++;
            if (busy) busy_seen = 1'b1;
        end while (!tick && n < 3000);
        check("tick_seen", int'(tick), 1);
    endtask

    task automatic load_and_run(input int tgt, input int step);
        target_div = CNT_W'(tgt);
        ramp_step = STEP_W'(step);
        target_valid = 1'b1;
        enable = 1'b1;
        cyc1();
        target_valid = 1'b0;
    endtask

    function automatic int move_toward(input int cur, input int tgt, input int st);
        if (st == 0) return tgt;
        if (cur < tgt) return (cur + st > tgt) ? tgt : cur + st;
        if (cur > tgt) return (cur - st < tgt) ? tgt : cur - st;
        return cur;
    endfunction

    initial begin
        int n;
        int exp_cur[3];
        int cyc_n, m_start, m_cur, m_tgt, td;
        bit m_run, m_clk, m_tick;

        tbl[0] = '{tgt: 99,   step: 0,   e1: 99,   e2: 99,   e3: 99,   busy_exp: 1'b0};
        tbl[1] = '{tgt: 875,  step: 100, e1: 1075, e2: 975,  e3: 875,  busy_exp: 1'b1};
        tbl[2] = '{tgt: 1200, step: 100, e1: 1200, e2: 1200, e3: 1200, busy_exp: 1'b1};
        tbl[3] = '{tgt: 0,    step: 0,   e1: 1,    e2: 1,    e3: 1,    busy_exp: 1'b0};
        tbl[4] = '{tgt: 1175, step: 50,  e1: 1175, e2: 1175, e3: 1175, busy_exp: 1'b0};
        tbl[5] = '{tgt: 1000, step: 200, e1: 1000, e2: 1000, e3: 1000, busy_exp: 1'b1};
        tbl[6] = '{tgt: 1170, step: 3,   e1: 1172, e2: 1170, e3: 1170, busy_exp: 1'b1};

        // Reset state and legacy divide ratio.
        do_reset();
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_cur_div", int'(cur_div), INIT);
        check("rst_at_target", int'(at_target), 1);
        check("rst_busy", int'(busy), 0);
        enable = 1'b1;
        wait_tick(n);
        check("legacy_first_half", n, 1176);
        check("legacy_clk_hi", int'(clk_out), 1);
        wait_tick(n);
        check("legacy_second_half", n, 1176);
        check("legacy_clk_lo", int'(clk_out), 0);
        check("legacy_busy", int'(busy), 0);

        // Single load from reset, then three output half-periods.
        foreach (tbl[i]) begin
            do_reset();
            busy_seen = 1'b0;
            load_and_run(tbl[i].tgt, tbl[i].step);
            exp_cur[0] = tbl[i].e1;
            exp_cur[1] = tbl[i].e2;
            exp_cur[2] = tbl[i].e3;
            wait_tick(n);
            check($sformatf("v%0d_half0", i), n + 1, INIT + 1);
            check($sformatf("v%0d_cur0", i), int'(cur_div), exp_cur[0]);
            for (int k = 1; k < 3; k++) begin
                wait_tick(n);
                check($sformatf("v%0d_half%0d", i, k), n, exp_cur[k-1] + 1);
                check($sformatf("v%0d_cur%0d", i, k), int'(cur_div), exp_cur[k]);
            end
            cyc1();
            check($sformatf("v%0d_busy_end", i), int'(busy), 0);
            check($sformatf("v%0d_at_target", i), int'(at_target), 1);
            check($sformatf("v%0d_busy_seen", i), int'(busy_seen), int'(tbl[i].busy_exp));
        end

        // Retarget in the middle of a ramp, reversing direction.
        do_reset();
        load_and_run(500, 100);
        wait_tick(n);
        check("rt_cur0", int'(cur_div), 1075);
        wait_tick(n);
        check("rt_cur1", int'(cur_div), 975);
        target_div = 16'd1100;
        target_valid = 1'b1;
        cyc1();
        target_valid = 1'b0;
        wait_tick(n);
        check("rt_half2", n + 1, 976);
        check("rt_cur2", int'(cur_div), 1075);
        check("rt_busy2", int'(busy), 1);
        wait_tick(n);
        check("rt_cur3", int'(cur_div), 1100);
        check("rt_busy3", int'(busy), 0);
        check("rt_at3", int'(at_target), 1);

        // Disable mid half-period, resume, then reset mid-ramp.
        do_reset();
        load_and_run(500, 100);
        wait_tick(n);
        repeat (10) cyc1();
        enable = 1'b0;
        cyc1();
        check("dis_clk_out", int'(clk_out), 0);
        check("dis_tick", int'(tick), 0);
        check("dis_cur", int'(cur_div), 1075);
        check("dis_busy", int'(busy), 1);
        repeat (5) cyc1();
        check("dis_cur_hold", int'(cur_div), 1075);
        enable = 1'b1;
        wait_tick(n);
        check("en_first_half", n, 1076);
        check("en_clk_hi", int'(clk_out), 1);
        check("en_cur", int'(cur_div), 975);
        reset = 1'b1;
        cyc1();
        reset = 1'b0;
        check("mrst_cur", int'(cur_div), INIT);
        check("mrst_busy", int'(busy), 0);
        check("mrst_clk", int'(clk_out), 0);
        check("mrst_at", int'(at_target), 1);
        check("mrst_tick", int'(tick), 0);

        // Randomized run against a timestamp-based reference model.
        do_reset();
        cyc_n = 0;
        m_run = 1'b0;
        m_clk = 1'b0;
        m_tick = 1'b0;
        m_cur = INIT;
        m_tgt = INIT;
        for (int i = 0; i < 6300; i++) begin
            enable = (i < 1300) ? 1'b1 : ($urandom_range(0, 99) < 96);
            if (i == 0) begin
                target_valid = 1'b1;
                target_div = 16'd60;
                ramp_step = '0;
            end else begin
                target_valid = ($urandom_range(0, 59) == 0);
                target_div = CNT_W'($urandom_range(0, 150));
                if ($urandom_range(0, 199) == 0) ramp_step = STEP_W'($urandom_range(0, 40));
            end
            td = int'(target_div);
            cyc_n++;
            if (!enable) begin
                m_run = 1'b0;
                m_clk = 1'b0;
                m_tick = 1'b0;
            end else begin
                if (!m_run) begin
                    m_run = 1'b1;
                    m_start = cyc_n - 1;
                end
                if (cyc_n - m_start == m_cur + 1) begin
                    m_clk = ~m_clk;
                    m_tick = 1'b1;
                    m_start = cyc_n;
                    m_cur = move_toward(m_cur, m_tgt, int'(ramp_step));
                end else begin
                    m_tick = 1'b0;
                end
            end
            if (target_valid) m_tgt = (td < DIV_MIN) ? DIV_MIN : td;
            cyc1();
            check("rnd_clk_out", int'(clk_out), int'(m_clk));
            check("rnd_tick", int'(tick), int'(m_tick));
            check("rnd_cur_div", int'(cur_div), m_cur);
            check("rnd_at_target", int'(at_target), int'(m_cur == m_tgt));
        end
        target_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
